// File: rtl/prism_sp_puzzle_fifo_arbiter.sv
// Packet-aware round-robin read arbiter draining NFIFOS FWFT puzzle FIFOs into one
// valid/ready stream, holding the grant for whole packets and up to a quota of packets.
module prism_sp_puzzle_fifo_arbiter #(
  parameter int NFIFOS      = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int QUOTA_WIDTH = 4,
  localparam int SW         = (NFIFOS > 1) ? $clog2(NFIFOS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NFIFOS-1:0]            fifo_empty,
  input  logic [NFIFOS*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NFIFOS-1:0]            fifo_rd_en,
  input  logic [NFIFOS-1:0]            src_enable,
  input  logic [QUOTA_WIDTH-1:0]       quota,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-2:0]        m_data,
  output logic                         m_last,
  output logic [SW-1:0]                m_src,
  output logic                         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]             state;
  logic [SW-1:0]          grant;
  logic [SW-1:0]          last_grant;
  logic [QUOTA_WIDTH-1:0] pkt_cnt;

  logic [NFIFOS-1:0]      req;
  logic [SW-1:0]          pick;
  logic                   pick_vld;
  logic [DATA_WIDTH-1:0]  head;
  logic                   xfer;
  logic                   cont;

  function automatic logic [QUOTA_WIDTH-1:0] quota_max(input logic [QUOTA_WIDTH-1:0] q);
    return (q == '0) ? QUOTA_WIDTH'(1) : q;
  endfunction

  function automatic logic [QUOTA_WIDTH-1:0] sat_inc(input logic [QUOTA_WIDTH-1:0] c);
    return (c == '1) ? c : c + QUOTA_WIDTH'(1);
  endfunction

  assign req = ~fifo_empty & src_enable;

  // Round-robin search starting just after the last source that finished a packet.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NFIFOS; k++) begin
      idx = (int'(last_grant) + k) % NFIFOS;
      if (!pick_vld && req[idx]) begin
        pick     = SW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign head    = fifo_rd_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign m_valid = (state == BUSY) && !fifo_empty[grant];
  assign m_data  = head[DATA_WIDTH-2:0];
  assign m_last  = head[DATA_WIDTH-1];
  assign m_src   = grant;
  assign busy    = (state != IDLE);
  assign xfer    = m_valid && m_ready;

  always_comb begin
    fifo_rd_en = '0;
    if (xfer) fifo_rd_en[grant] = 1'b1;
  end

  // Evaluated in the cycle after a last-beat pop, once the FIFO's empty flag reflects the pop.
  assign cont = (({1'b0, pkt_cnt} + (QUOTA_WIDTH+1)'(1)) < {1'b0, quota_max(quota)})
                && src_enable[grant] && !fifo_empty[grant];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(NFIFOS-1);
      pkt_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant   <= pick;
            pkt_cnt <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && m_last) begin
            last_grant <= grant;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (cont) begin
            pkt_cnt <= sat_inc(pkt_cnt);
            state   <= BUSY;
          end else begin
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prism_sp_puzzle_fifo_arbiter.sv
// Bench for prism_sp_puzzle_fifo_arbiter: FWFT FIFO models feed the arbiter and a
// scoreboard of expected (source, word) pairs is checked on every accepted beat.
module tb_prism_sp_puzzle_fifo_arbiter;
  localparam int NF = 4;
  localparam int DW = 64;
  localparam int QW = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] w;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NF-1:0]    fifo_empty;
  logic [NF*DW-1:0] fifo_rd_data;
  logic [NF-1:0]    fifo_rd_en;
  logic [NF-1:0]    src_enable;
  logic [QW-1:0]    quota;
  logic             m_valid;
  logic             m_ready;
  logic [DW-2:0]    m_data;
  logic             m_last;
  logic [SW-1:0]    m_src;
  logic             busy;

  prism_sp_puzzle_fifo_arbiter #(.NFIFOS(NF), .DATA_WIDTH(DW), .QUOTA_WIDTH(QW)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .src_enable(src_enable), .quota(quota), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_src(m_src), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] q [NF][$];
  exp_t          sb[$];
  int            xfer_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            xfer_cnt;
  int            rd_cnt [NF];
  bit            toggle_ready;
  bit            stalled_prev;
  logic [DW-1:0] held_w;
  logic [SW-1:0] held_src;

  function automatic logic [DW-1:0] mkw(int s, int id, bit last);
    logic [DW-1:0] w;
    w = DW'((s << 8) | id);
    w[DW-1] = last;
    return w;
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_rd_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(int s, logic [DW-1:0] w);
    q[s].push_back(w);
    drive_fifos();
  endtask

  task automatic expect_beat(int s, logic [DW-1:0] w);
    exp_t e;
    e.src = SW'(s);
    e.w   = w;
    sb.push_back(e);
  endtask

  // One clock: sample at negedge+, pop the models after the posedge, return at next negedge.
  task automatic cycle();
    logic [NF-1:0] exp_rd;
    logic [NF-1:0] rd_snap;
    exp_t          e;
    if (toggle_ready) m_ready = ~m_ready;
    #1;
    exp_rd = '0;
    if (m_valid && m_ready) exp_rd[m_src] = 1'b1;
    n_cmp++;
    if (fifo_rd_en !== exp_rd) begin
      n_err++;
      $display("FAIL rd_en cyc=%0d got=%b want=%b", cyc, fifo_rd_en, exp_rd);
    end
    for (int i = 0; i < NF; i++) begin
      if (fifo_rd_en[i] === 1'b1) begin
        rd_cnt[i]++;
        n_cmp++;
        if (q[i].size() == 0) begin
          n_err++;
          $display("FAIL pop_empty cyc=%0d fifo=%0d got=pop want=no_pop", cyc, i);
        end
      end
    end
    if (stalled_prev) begin
      n_cmp++;
      if (m_valid !== 1'b1 || {m_src, m_last, m_data} !== {held_src, held_w}) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d got=%b/%0d/%h want=1/%0d/%h",
                 cyc, m_valid, m_src, {m_last, m_data}, held_src, held_w);
      end
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      xfer_cnt++;
      xfer_cyc.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat cyc=%0d got=%0d/%h want=none", cyc, m_src, {m_last, m_data});
      end else begin
        e = sb.pop_front();
        if (m_src !== e.src || {m_last, m_data} !== e.w) begin
          n_err++;
          $display("FAIL beat cyc=%0d got=%0d/%h want=%0d/%h", cyc, m_src, {m_last, m_data}, e.src, e.w);
        end
      end
    end
    stalled_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
    held_w   = {m_last, m_data};
    held_src = m_src;
    rd_snap  = fifo_rd_en;
    @(posedge clock);
    #1;
    for (int i = 0; i < NF; i++)
      if (rd_snap[i] === 1'b1 && q[i].size() != 0) void'(q[i].pop_front());
    drive_fifos();
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout got=%0d_pending want=0", sb.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < NF; i++) q[i].delete();
    drive_fifos();
    m_ready = 1'b1;
    toggle_ready = 1'b0;
    src_enable = '1;
    cycle();
    cycle();
    reset = 1'b0;
    xfer_cnt = 0;
    xfer_cyc.delete();
    stalled_prev = 1'b0;
    for (int i = 0; i < NF; i++) rd_cnt[i] = 0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    n_cmp++;
    if ({m_valid, fifo_rd_en, busy, m_src} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=0", {m_valid, fifo_rd_en, busy, m_src});
    end
    @(negedge clock);
  endtask

  task automatic test_single();
    do_reset();
    quota = 4'd1;
    for (int k = 0; k < 3; k++) begin
      push(2, mkw(2, k, k == 2));
      expect_beat(2, mkw(2, k, k == 2));
    end
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle got=%b%b want=00", m_valid, busy);
    end
    cycle();
    #1;
    n_cmp++;
    if (m_valid !== 1'b1 || m_src !== 2'd2) begin
      n_err++;
      $display("FAIL single_latency got=%b/%0d want=1/2", m_valid, m_src);
    end
    drain(20);
    n_cmp++;
    if (rd_cnt[2] != 3 || xfer_cnt != 3 || xfer_cyc[2] - xfer_cyc[0] != 2) begin
      n_err++;
      $display("FAIL single_pops got=%0d/%0d want=3/3 consecutive", rd_cnt[2], xfer_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    quota = 4'd1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NF; s++) begin
        push(s, mkw(s, p, 1'b1));
        expect_beat(s, mkw(s, p, 1'b1));
      end
    drain(60);
    n_cmp++;
    if (xfer_cnt != 8) begin
      n_err++;
      $display("FAIL rr_count got=%0d want=8", xfer_cnt);
    end
  endtask

  task automatic test_quota();
    do_reset();
    quota = 4'd3;
    for (int p = 0; p < 5; p++) push(1, mkw(1, p, 1'b1));
    cycle();
    push(0, mkw(0, 9, 1'b1));
    for (int p = 0; p < 3; p++) expect_beat(1, mkw(1, p, 1'b1));
    expect_beat(0, mkw(0, 9, 1'b1));
    for (int p = 3; p < 5; p++) expect_beat(1, mkw(1, p, 1'b1));
    drain(60);
    n_cmp++;
    if (xfer_cyc.size() != 6 || xfer_cyc[1] - xfer_cyc[0] != 2 || xfer_cyc[3] - xfer_cyc[2] != 3) begin
      n_err++;
      $display("FAIL quota_gaps got=%0d beats want=6 with gaps 2,3", xfer_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    quota = 4'd0;
    push(1, mkw(1, 0, 1'b1));
    push(1, mkw(1, 1, 1'b1));
    push(2, mkw(2, 0, 1'b1));
    expect_beat(1, mkw(1, 0, 1'b1));
    expect_beat(2, mkw(2, 0, 1'b1));
    expect_beat(1, mkw(1, 1, 1'b1));
    drain(40);
    n_cmp++;
    if (xfer_cyc.size() != 3 || xfer_cyc[1] - xfer_cyc[0] != 3 || xfer_cyc[2] - xfer_cyc[1] != 3) begin
      n_err++;
      $display("FAIL b2b_gap got=%0d beats want=3 with gap 3", xfer_cyc.size());
    end
  endtask

  task automatic test_underflow();
    int n;
    do_reset();
    quota = 4'd1;
    toggle_ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_beat(3, mkw(3, k, k == 3));
    expect_beat(0, mkw(0, 7, 1'b1));
    push(3, mkw(3, 0, 1'b0));
    push(3, mkw(3, 1, 1'b0));
    n = 0;
    while (q[3].size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    push(0, mkw(0, 7, 1'b1));
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++;
      if (m_valid !== 1'b0 || m_src !== 2'd3 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL underflow_hold got=%b/%0d/%b want=0/3/1", m_valid, m_src, busy);
      end
    end
    push(3, mkw(3, 2, 1'b0));
    push(3, mkw(3, 3, 1'b1));
    drain(60);
    toggle_ready = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_disable();
    int n;
    do_reset();
    quota = 4'd4;
    for (int k = 0; k < 3; k++) push(0, mkw(0, k, k == 2));
    push(0, mkw(0, 5, 1'b1));
    push(1, mkw(1, 0, 1'b1));
    push(2, mkw(2, 0, 1'b1));
    for (int k = 0; k < 3; k++) expect_beat(0, mkw(0, k, k == 2));
    expect_beat(1, mkw(1, 0, 1'b1));
    expect_beat(2, mkw(2, 0, 1'b1));
    n = 0;
    while (xfer_cnt < 1 && n < 20) begin
      cycle();
      n++;
    end
    src_enable[0] = 1'b0;
    drain(60);
    for (int k = 0; k < 8; k++) cycle();
    n_cmp++;
    if (q[0].size() != 1 || xfer_cnt != 5) begin
      n_err++;
      $display("FAIL disable_left got=%0d/%0d want=1/5", q[0].size(), xfer_cnt);
    end
    src_enable = '1;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    quota = 4'd1;
    for (int k = 0; k < 3; k++) begin
      push(2, mkw(2, k, k == 2));
      expect_beat(2, mkw(2, k, k == 2));
    end
    n = 0;
    while (xfer_cnt < 1 && n < 20) begin
      cycle();
      n++;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({m_valid, fifo_rd_en, busy} !== '0) begin
      n_err++;
      $display("FAIL async_reset got=%b want=0", {m_valid, fifo_rd_en, busy});
    end
    sb.delete();
    push(0, mkw(0, 3, 1'b1));
    expect_beat(0, mkw(0, 3, 1'b1));
    expect_beat(2, mkw(2, 1, 1'b0));
    expect_beat(2, mkw(2, 2, 1'b1));
    cycle();
    reset = 1'b0;
    stalled_prev = 1'b0;
    drain(40);
    n_cmp++;
    if (q[2].size() != 0 || q[0].size() != 0) begin
      n_err++;
      $display("FAIL reset_resume got=%0d/%0d want=0/0", q[0].size(), q[2].size());
    end
  endtask

  initial begin
    reset = 1'b1;
    m_ready = 1'b1;
    toggle_ready = 1'b0;
    stalled_prev = 1'b0;
    src_enable = '1;
    quota = 4'd1;
    xfer_cnt = 0;
    for (int i = 0; i < NF; i++) rd_cnt[i] = 0;
    drive_fifos();
    test_reset();
    test_single();
    test_round_robin();
    test_quota();
    test_back_to_back();
    test_underflow();
    test_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
